univ_shift_reg: RTL

//  - Parametrised universal register: hold, shift-left, shift-right, parallel load, optional rotate.
//  - Adds an autonomous burst-shift engine: one command performs N shifts, one per enabled cycle.
//  - Used for serialisers, deserialisers and barrel-style alignment in datapath slices.
//  - Replaces ad-hoc banks of single-bit D flops with synchronous reset.

---
 rtl/univ_shift_reg.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parametrised universal register (hold, shift left, shift right,
// parallel load, optional rotate) with an autonomous burst-shift engine.
// A burst command performs burst_len shifts, one per enabled cycle, then pulses done.
// Optional feature macro: USR_PARITY_EN adds a registered even-parity output
// that always describes the current q.
module univ_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter int               CNT_W     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             rotate,
  input  logic             burst_start,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             burst_dir,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
`ifdef USR_PARITY_EN
  ,
  output logic             parity
`endif
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_RIGHT = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             dir_reg, dir_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic             done_reg, done_next;

  // Candidate values for a single left or right shift of the current contents.
  // The end bit takes either the serial input or, when rotating, the bit that
  // falls off the opposite end.
  logic [WIDTH-1:0] shl_vec;
  logic [WIDTH-1:0] shr_vec;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == 0) begin : g_shl_lsb
        assign shl_vec[gi] = rotate ? q_reg[WIDTH-1] : sin_r;
      end else begin : g_shl_body
        assign shl_vec[gi] = q_reg[gi-1];
      end

      if (gi == WIDTH - 1) begin : g_shr_msb
        assign shr_vec[gi] = rotate ? q_reg[0] : sin_l;
      end else begin : g_shr_body
        assign shr_vec[gi] = q_reg[gi+1];
      end
    end
  endgenerate

  // Next-state logic: everything holds when en=0, except done which always
  // falls back to 0 so it stays a single-cycle pulse.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dir_next   = dir_reg;
    q_next     = q_reg;
    done_next  = 1'b0;

    if (en) begin
      unique case (state_reg)
        ST_IDLE: begin
          if (burst_start) begin
            // A zero-length burst completes immediately without touching q.
            if (burst_len == '0) begin
              done_next = 1'b1;
            end else begin
              cnt_next   = burst_len;
              dir_next   = burst_dir;
              state_next = ST_BURST;
            end
          end else begin
            case (mode)
              MODE_LEFT:  q_next = shl_vec;
              MODE_RIGHT: q_next = shr_vec;
              MODE_LOAD:  q_next = d;
              MODE_HOLD:  q_next = q_reg;
              default:    q_next = q_reg;
            endcase
          end
        end

        ST_BURST: begin
          // One shift per enabled edge in the direction latched at start;
          // rotate and the serial inputs are taken live.
          q_next   = dir_reg ? shr_vec : shl_vec;
          cnt_next = cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // State register; reset aborts any burst in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      dir_reg   <= 1'b0;
      q_reg     <= RESET_VAL;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      dir_reg   <= dir_next;
      q_reg     <= q_next;
      done_reg  <= done_next;
    end
  end

  assign q      = q_reg;
  assign sout_l = q_reg[WIDTH-1];
  assign sout_r = q_reg[0];
  assign busy   = (state_reg == ST_BURST);
  assign done   = done_reg;

`ifdef USR_PARITY_EN
  logic parity_reg;

  // Parity is computed from the value about to be registered so it lines up with q.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_reg <= ^RESET_VAL;
    end else begin
      parity_reg <= ^q_next;
    end
  end

  assign parity = parity_reg;
`endif

endmodule
